// File: rtl/neptune_pkg.sv
// Shared definitions for the Neptune register array: clear-sequencer states and fault counter width.
package neptune_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clr_state_e;

    localparam int FAULT_CNT_W = 8;

endpackage

// File: rtl/reg_wr_arbiter.sv
// Per-address write arbitration: the highest-index enabled port targeting an address wins;
// flags a collision when two or more enabled ports target the same address.
module reg_wr_arbiter #(
    parameter int NW    = 2,
    parameter int AW    = 3,
    parameter int DEPTH = 8,
    parameter int PW    = 1
) (
    input  logic [NW-1:0]    we_i,
    input  logic [NW*AW-1:0] wadd_i,
    output logic [DEPTH-1:0] addr_we_o,
    output logic [PW-1:0]    addr_sel_o [DEPTH],
    output logic             collision_o
);

    always_comb begin
        addr_we_o   = '0;
        collision_o = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            addr_sel_o[a] = '0;
            // Ascending scan so a later (higher-index) port overrides earlier ones.
            for (int i = 0; i < NW; i++) begin
                if (we_i[i] && (wadd_i[i*AW +: AW] == AW'(a))) begin
                    if (addr_we_o[a]) collision_o = 1'b1;
                    addr_we_o[a]  = 1'b1;
                    addr_sel_o[a] = PW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/reg_array_multi.sv
// Multi-port register array with registered reads, prioritised writes, optional bypass and zero
// register, write-collision fault monitor and a sequenced clear of the whole array.
module reg_array_multi
    import neptune_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int AW       = 3,
    parameter int NR       = 2,
    parameter int NW       = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NW-1:0]          we,
    input  logic [NW*AW-1:0]       wadd,
    input  logic [NW*WIDTH-1:0]    wdata,
    input  logic [NR*AW-1:0]       radd,
    output logic [NR*WIDTH-1:0]    rdata,
    input  logic                   clr_req,
    output logic                   clr_busy,
    output logic                   clr_done,
    input  logic                   flt_clr,
    output logic                   mem_fault,
    output logic [AW-1:0]          fault_add,
    output logic [FAULT_CNT_W-1:0] fault_cnt
);

    localparam int PW = (NW > 1) ? $clog2(NW) : 1;

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [WIDTH-1:0]       wdata_a [NW];
    logic [NW-1:0]          we_ok;
    logic [DEPTH-1:0]       addr_we;
    logic [PW-1:0]          addr_sel [DEPTH];
    logic                   collision;

    clr_state_e             state_q, state_d;
    logic [AW-1:0]          ptr_q, ptr_d;
    logic                   fault_q, fault_d;
    logic [AW-1:0]          fault_add_q, fault_add_d;
    logic [FAULT_CNT_W-1:0] fault_cnt_q, fault_cnt_d;

    assign clr_busy = (state_q != ST_IDLE);
    assign clr_done = (state_q == ST_DONE);

    // Writes are filtered before arbitration so discarded writes never count as collisions.
    generate
        for (genvar i = 0; i < NW; i++) begin : g_wr
            logic [AW-1:0] wa;
            assign wa         = wadd[i*AW +: AW];
            assign wdata_a[i] = wdata[i*WIDTH +: WIDTH];
            assign we_ok[i]   = we[i] && !clr_busy && (32'(wa) < DEPTH)
                                && !((ZERO_REG != 0) && (wa == '0));
        end
    endgenerate

    reg_wr_arbiter #(
        .NW    (NW),
        .AW    (AW),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_arb (
        .we_i        (we_ok),
        .wadd_i      (wadd),
        .addr_we_o   (addr_we),
        .addr_sel_o  (addr_sel),
        .collision_o (collision)
    );

    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem_q[ptr_q] <= '0;
        end else begin
            for (int a = 0; a < DEPTH; a++) begin
                if (addr_we[a]) mem_q[a] <= wdata_a[addr_sel[a]];
            end
        end
    end

    generate
        for (genvar j = 0; j < NR; j++) begin : g_rd
            logic [AW-1:0]    ra;
            logic [WIDTH-1:0] rd_d, rd_q;
            assign ra = radd[j*AW +: AW];
            always_comb begin
                rd_d = '0;
                if ((32'(ra) < DEPTH) && !((ZERO_REG != 0) && (ra == '0))) begin
                    if ((BYPASS != 0) && addr_we[ra]) rd_d = wdata_a[addr_sel[ra]];
                    else                              rd_d = mem_q[ra];
                end
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) rd_q <= '0;
                else        rd_q <= rd_d;
            end
            assign rdata[j*WIDTH +: WIDTH] = rd_q;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (ptr_q == AW'(DEPTH - 1)) state_d = ST_DONE;
                else                         ptr_d   = ptr_q + 1'b1;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fault_d     = fault_q;
        fault_add_d = fault_add_q;
        fault_cnt_d = fault_cnt_q;
        if (flt_clr) begin
            fault_d     = 1'b0;
            fault_add_d = '0;
            fault_cnt_d = '0;
        end else if (collision) begin
            fault_d = 1'b1;
            if (!fault_q) begin
                for (int a = DEPTH - 1; a >= 0; a--) begin
                    if (addr_we[a] && ($countones(we_ok & sel_mask(a)) > 1)) fault_add_d = AW'(a);
                end
            end
            if (fault_cnt_q != '1) fault_cnt_d = fault_cnt_q + 1'b1;
        end
    end

    function automatic logic [NW-1:0] sel_mask(input int a);
        logic [NW-1:0] m;
        m = '0;
        for (int i = 0; i < NW; i++) begin
            m[i] = (wadd[i*AW +: AW] == AW'(a));
        end
        return m;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            fault_q     <= 1'b0;
            fault_add_q <= '0;
            fault_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            fault_q     <= fault_d;
            fault_add_q <= fault_add_d;
            fault_cnt_q <= fault_cnt_d;
        end
    end

    assign mem_fault = fault_q;
    assign fault_add = fault_add_q;
    assign fault_cnt = fault_cnt_q;

endmodule

// File: tb/tb_reg_array_multi.sv
// Directed bench for reg_array_multi: default, no-bypass and zero-register instances share stimulus.
module tb_reg_array_multi;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  we = '0;
    logic [5:0]  wadd = '0;
    logic [31:0] wdata = '0;
    logic [5:0]  radd = '0;
    logic        clr_req = 1'b0;
    logic        flt_clr = 1'b0;

    logic [31:0] rdata_a, rdata_b, rdata_z;
    logic        busy_a, busy_b, busy_z;
    logic        done_a, done_b, done_z;
    logic        flt_a, flt_b, flt_z;
    logic [2:0]  fadd_a, fadd_b, fadd_z;
    logic [7:0]  fcnt_a, fcnt_b, fcnt_z;

    int n_assert = 0;
    int n_fail   = 0;
    int busy_cnt, done_cnt;

    always #5 clk = ~clk;

    reg_array_multi #(.BYPASS(1), .ZERO_REG(0)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .wadd(wadd), .wdata(wdata), .radd(radd),
        .rdata(rdata_a), .clr_req(clr_req), .clr_busy(busy_a), .clr_done(done_a),
        .flt_clr(flt_clr), .mem_fault(flt_a), .fault_add(fadd_a), .fault_cnt(fcnt_a));

    reg_array_multi #(.BYPASS(0), .ZERO_REG(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .we(we), .wadd(wadd), .wdata(wdata), .radd(radd),
        .rdata(rdata_b), .clr_req(clr_req), .clr_busy(busy_b), .clr_done(done_b),
        .flt_clr(flt_clr), .mem_fault(flt_b), .fault_add(fadd_b), .fault_cnt(fcnt_b));

    reg_array_multi #(.BYPASS(1), .ZERO_REG(1)) dut_z (
        .clk(clk), .rst_n(rst_n), .we(we), .wadd(wadd), .wdata(wdata), .radd(radd),
        .rdata(rdata_z), .clr_req(clr_req), .clr_busy(busy_z), .clr_done(done_z),
        .flt_clr(flt_clr), .mem_fault(flt_z), .fault_add(fadd_z), .fault_cnt(fcnt_z));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        step();
        check("rst_rdata",   rdata_a, 32'h0);
        check("rst_busy",    {31'b0, busy_a}, 32'h0);
        check("rst_done",    {31'b0, done_a}, 32'h0);
        check("rst_fault",   {31'b0, flt_a}, 32'h0);
        check("rst_fadd",    {29'b0, fadd_a}, 32'h0);
        check("rst_fcnt",    {24'b0, fcnt_a}, 32'h0);
        rst_n = 1'b1;
        step();

        // 1. Array clear
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy_a) busy_cnt++;
            if (done_a) done_cnt++;
            if (!busy_a) break;
            step();
        end
        check("clr_busy_cycles", busy_cnt, 32'd9);
        check("clr_done_pulses", done_cnt, 32'd1);
        for (int a = 0; a < 8; a++) begin
            radd = {3'(a), 3'(a)};
            step();
            check($sformatf("clr_read_%0d", a), rdata_a, 32'h0);
        end

        // 2. Simple write then read
        we = 2'b01; wadd = {3'd0, 3'd3}; wdata = {16'h0, 16'hBEEF};
        step();
        we = 2'b00; radd = {3'd0, 3'd3};
        step();
        check("wr_read_3",   {16'h0, rdata_a[15:0]}, 32'h0000BEEF);
        check("wr_no_fault", {31'b0, flt_a}, 32'h0);

        // 3. Collisions and fault clear
        we = 2'b11; wadd = {3'd5, 3'd5}; wdata = {16'h2222, 16'h1111};
        step();
        we = 2'b00;
        check("col1_fault", {31'b0, flt_a}, 32'h1);
        check("col1_fadd",  {29'b0, fadd_a}, 32'd5);
        check("col1_fcnt",  {24'b0, fcnt_a}, 32'd1);
        radd = {3'd0, 3'd5};
        step();
        check("col1_winner", {16'h0, rdata_a[15:0]}, 32'h00002222);
        we = 2'b11; wadd = {3'd6, 3'd6}; wdata = {16'h6666, 16'h3333};
        step();
        we = 2'b00;
        check("col2_fadd", {29'b0, fadd_a}, 32'd5);
        check("col2_fcnt", {24'b0, fcnt_a}, 32'd2);
        flt_clr = 1'b1;
        step();
        flt_clr = 1'b0;
        check("fclr_fault", {31'b0, flt_a}, 32'h0);
        check("fclr_fadd",  {29'b0, fadd_a}, 32'h0);
        check("fclr_fcnt",  {24'b0, fcnt_a}, 32'h0);

        // 4. Bypass versus no bypass
        we = 2'b01; wadd = {3'd0, 3'd2}; wdata = {16'h0, 16'h1234};
        step();
        wdata = {16'h0, 16'hA5A5}; radd = {3'd2, 3'd0};
        step();
        we = 2'b00;
        check("byp_on",  {16'h0, rdata_a[31:16]}, 32'h0000A5A5);
        check("byp_off", {16'h0, rdata_b[31:16]}, 32'h00001234);
        step();
        check("byp_off_next", {16'h0, rdata_b[31:16]}, 32'h0000A5A5);

        // 5. Zero register
        we = 2'b01; wadd = {3'd0, 3'd0}; wdata = {16'h0, 16'hFFFF};
        step();
        we = 2'b11; wdata = {16'hFFFF, 16'h0F0F}; radd = {3'd0, 3'd0};
        step();
        we = 2'b00;
        check("zero_read",     {16'h0, rdata_z[15:0]}, 32'h0);
        check("zero_no_fault", {31'b0, flt_z}, 32'h0);
        check("zero_no_fcnt",  {24'b0, fcnt_z}, 32'h0);
        check("nz_bypass_win", {16'h0, rdata_a[15:0]}, 32'h0000FFFF);
        check("nz_fault",      {31'b0, flt_a}, 32'h1);
        step();
        check("zero_read_next", {16'h0, rdata_z[15:0]}, 32'h0);
        flt_clr = 1'b1;
        step();
        flt_clr = 1'b0;

        // 6. Reset aborts a clear part way through
        we = 2'b11; wadd = {3'd1, 3'd6}; wdata = {16'h1111, 16'h6666};
        step();
        we = 2'b00;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        we = 2'b11; wadd = {3'd6, 3'd6}; wdata = {16'hDEAD, 16'hDEAD}; radd = {3'd0, 3'd6};
        for (int k = 0; k < 4; k++) step();
        check("clr_live_read",   {16'h0, rdata_a[15:0]}, 32'h00006666);
        check("clr_wr_no_fault", {31'b0, flt_a}, 32'h0);
        check("clr_busy_mid",    {31'b0, busy_a}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("abort_rdata", rdata_a, 32'h0);
        check("abort_busy",  {31'b0, busy_a}, 32'h0);
        check("abort_done",  {31'b0, done_a}, 32'h0);
        we = 2'b00;
        step();
        rst_n = 1'b1;
        step();
        check("abort_idle", {31'b0, busy_a}, 32'h0);
        radd = {3'd5, 3'd6};
        step();
        check("abort_keep_6", {16'h0, rdata_a[15:0]}, 32'h00006666);
        check("abort_keep_5", {16'h0, rdata_a[31:16]}, 32'h00002222);
        radd = {3'd3, 3'd1};
        step();
        check("abort_clr_1", {16'h0, rdata_a[15:0]}, 32'h0);
        check("abort_clr_3", {16'h0, rdata_a[31:16]}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
